// File: rtl/img_pkg.sv
// Shared image geometry defaults and scheduler state encoding for the 3x3 window path.
package img_pkg;

    localparam int IMG_WIDTH  = 512;
    localparam int IMG_HEIGHT = 512;
    localparam int PIX_W      = 8;
    localparam int PRIME_ROWS = 4;
    localparam int ROW_CNT_W  = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        WAIT  = 3'd2,
        FEED  = 3'd3,
        DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/row_feed_scheduler.sv
// Meters source pixels into the window controller: primes four row buffers, then
// releases one row per window-row interrupt so an unread row is never overwritten.
module row_feed_scheduler #(
    parameter int IMG_WIDTH  = img_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = img_pkg::IMG_HEIGHT,
    parameter int PIX_W      = img_pkg::PIX_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [PIX_W-1:0]              src_data,
    input  logic                          src_valid,
    output logic                          src_ready,
    output logic [PIX_W-1:0]              pix_out,
    output logic                          pix_out_valid,
    input  logic                          win_interrupt,
    output logic                          busy,
    output logic                          frame_done,
    output logic [img_pkg::ROW_CNT_W-1:0] rows_sent,
    output logic [img_pkg::ROW_CNT_W-1:0] rows_done,
    output logic                          credit_err
);
    import img_pkg::*;

    localparam int BEAT_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [BEAT_W-1:0]    LAST_BEAT   = BEAT_W'(IMG_WIDTH - 1);
    localparam logic [ROW_CNT_W-1:0] HEIGHT_ROWS = ROW_CNT_W'(IMG_HEIGHT);
    localparam logic [ROW_CNT_W-1:0] DONE_ROWS   = ROW_CNT_W'(IMG_HEIGHT - 2);
    localparam logic [ROW_CNT_W-1:0] PRIME_LAST  = ROW_CNT_W'(PRIME_ROWS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [1:0]        credits;
    logic              beat;
    logic              row_wrap;
    logic              start_acc;
    logic              credit_add;
    logic              credit_take;
    logic              frame_end;

    assign beat       = src_valid & src_ready;
    assign row_wrap   = beat && (beat_cnt == LAST_BEAT);
    assign start_acc  = (state == IDLE) && start;
    // Interrupts seen while idle belong to no frame, so they earn no credit.
    assign credit_add = win_interrupt && (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        credit_take = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = PRIME;
            end
            PRIME: begin
                if (row_wrap && (rows_sent == PRIME_LAST)) state_nxt = WAIT;
            end
            WAIT: begin
                if (rows_sent == HEIGHT_ROWS) begin
                    state_nxt = DRAIN;
                end else if (credits != 2'd0) begin
                    state_nxt   = FEED;
                    credit_take = 1'b1;
                end
            end
            FEED: begin
                if (row_wrap) state_nxt = WAIT;
            end
            DRAIN: begin
                // The last two rows never complete a window row, so the frame ends two short.
                if (rows_done == DONE_ROWS) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_ready     <= 1'b0;
            pix_out       <= '0;
            pix_out_valid <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            rows_sent     <= '0;
            rows_done     <= '0;
            credit_err    <= 1'b0;
            credits       <= 2'd0;
            beat_cnt      <= '0;
        end else begin
            // Registered from the next state so ready never depends on src_valid.
            src_ready     <= (state_nxt == PRIME) || (state_nxt == FEED);
            pix_out_valid <= beat;
            if (beat) pix_out <= src_data;
            frame_done    <= frame_end;

            if (start_acc) begin
                busy <= 1'b1;
            end else if (frame_end) begin
                busy <= 1'b0;
            end

            if (start_acc) begin
                beat_cnt  <= '0;
                rows_sent <= '0;
            end else if (beat) begin
                beat_cnt <= row_wrap ? '0 : beat_cnt + 1'b1;
                if (row_wrap) rows_sent <= rows_sent + 1'b1;
            end

            if (start_acc) begin
                rows_done <= '0;
            end else if (win_interrupt) begin
                rows_done <= rows_done + 1'b1;
            end

            if (start_acc) begin
                credits    <= 2'd0;
                credit_err <= 1'b0;
            end else if ((state == WAIT) && (state_nxt == DRAIN)) begin
                credits <= 2'd0;
            end else begin
                case ({credit_add, credit_take})
                    2'b10: begin
                        if (credits == 2'd3) credit_err <= 1'b1;
                        else                 credits    <= credits + 2'd1;
                    end
                    2'b01:   credits <= credits - 2'd1;
                    default: credits <= credits;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_row_feed_scheduler.sv
// Scoreboard bench for row_feed_scheduler with an 8x6 frame.
module tb_row_feed_scheduler;
    import img_pkg::*;

    localparam int W = 8;
    localparam int H = 6;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [PW-1:0] src_data;
    logic          src_valid;
    logic          src_ready;
    logic [PW-1:0] pix_out;
    logic          pix_out_valid;
    logic          win_interrupt;
    logic          busy;
    logic          frame_done;
    logic [11:0]   rows_sent;
    logic [11:0]   rows_done;
    logic          credit_err;

    int            tests_run = 0;
    int            tests_failed = 0;
    logic [PW-1:0] sb_q[$];
    logic [PW-1:0] last_pix = '0;
    int            acc_cnt = 0;
    int            fd_cnt = 0;
    int            seq = 0;
    bit            adv = 0;
    bit            mon_en = 0;

    row_feed_scheduler #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .pix_out(pix_out), .pix_out_valid(pix_out_valid),
        .win_interrupt(win_interrupt), .busy(busy), .frame_done(frame_done),
        .rows_sent(rows_sent), .rows_done(rows_done), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard: accepted beats are queued at the negedge before the edge that takes them.
    always @(negedge clk) begin
        if (mon_en) begin
            if (pix_out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_beat", 32'd1, 32'd0);
                end else begin
                    last_pix = sb_q.pop_front();
                    check_eq("pix_out", 32'(pix_out), 32'(last_pix));
                end
            end else begin
                check_eq("pix_hold", 32'(pix_out), 32'(last_pix));
            end
            if (frame_done === 1'b1) fd_cnt++;
        end
        if (rst) begin
            sb_q.delete();
            last_pix = '0;
        end else if (src_valid === 1'b1 && src_ready === 1'b1) begin
            sb_q.push_back(src_data);
            acc_cnt++;
            adv = 1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (adv) begin
            adv = 0;
            seq++;
            src_data = PW'(seq * 37 + 11);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_int();
        step();
        win_interrupt = 1'b1;
        step();
        win_interrupt = 1'b0;
    endtask

    task automatic start_frame();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_state(input state_t s, input int limit, input string tag);
        int n = 0;
        while (dut.state != s && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(dut.state), 32'(s));
    endtask

    task automatic wait_frame_done(input int limit, input string tag);
        int n = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(frame_done), 32'd1);
    endtask

    task automatic count_ready(input int expect_hi, input string tag);
        int cnt = 0;
        while (src_ready === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check_eq(tag, 32'(cnt), 32'(expect_hi));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_src_ready"}, 32'(src_ready), 32'd0);
        check_eq({tag, "_pix_out"}, 32'(pix_out), 32'd0);
        check_eq({tag, "_pix_out_valid"}, 32'(pix_out_valid), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check_eq({tag, "_rows_sent"}, 32'(rows_sent), 32'd0);
        check_eq({tag, "_rows_done"}, 32'(rows_done), 32'd0);
        check_eq({tag, "_credit_err"}, 32'(credit_err), 32'd0);
        check_eq({tag, "_state"}, 32'(dut.state), 32'(IDLE));
        check_eq({tag, "_credits"}, 32'(dut.credits), 32'd0);
    endtask

    // Interrupt from WAIT with no credit: one credit, then FEED with ready a cycle later.
    task automatic feed_one(input int exp_rows, input string tag);
        int acc0 = acc_cnt;
        pulse_int();
        @(negedge clk);
        check_eq({tag, "_credit1"}, 32'(dut.credits), 32'd1);
        check_eq({tag, "_rdy_low"}, 32'(src_ready), 32'd0);
        @(negedge clk);
        check_eq({tag, "_rdy_high"}, 32'(src_ready), 32'd1);
        check_eq({tag, "_feed"}, 32'(dut.state), 32'(FEED));
        repeat (18) @(negedge clk);
        check_eq({tag, "_beats"}, 32'(acc_cnt - acc0), 32'(W));
        check_eq({tag, "_rows_sent"}, 32'(rows_sent), 32'(exp_rows));
    endtask

    logic pat[4];
    int   acc0;
    int   hi;

    initial begin
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = '0; win_interrupt = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        mon_en = 1;

        // Idle interrupt: counted, no credit, no error.
        pulse_int();
        @(negedge clk);
        check_eq("idle_int_rows_done", 32'(rows_done), 32'd1);
        check_eq("idle_int_credits", 32'(dut.credits), 32'd0);
        check_eq("idle_int_err", 32'(credit_err), 32'd0);

        // Prime with src_valid tied high.
        step();
        src_valid = 1'b1;
        acc0 = acc_cnt;
        fd_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        check_eq("rdy_before_start", 32'(src_ready), 32'd0);
        step();
        start = 1'b0;
        @(negedge clk);
        check_eq("rdy_after_start", 32'(src_ready), 32'd1);
        check_eq("busy_after_start", 32'(busy), 32'd1);
        check_eq("rows_done_cleared", 32'(rows_done), 32'd0);
        count_ready(4 * W, "prime_ready_cycles");
        check_eq("prime_rows_sent", 32'(rows_sent), 32'd4);
        check_eq("prime_state", 32'(dut.state), 32'(WAIT));
        @(negedge clk);
        check_eq("prime_beats", 32'(acc_cnt - acc0), 32'(4 * W));
        check_eq("prime_sb_empty", 32'(sb_q.size()), 32'd0);

        feed_one(5, "feed1");
        feed_one(6, "feed2");
        @(negedge clk);
        check_eq("drain_state", 32'(dut.state), 32'(DRAIN));
        check_eq("drain_credits", 32'(dut.credits), 32'd0);
        pulse_int();
        @(negedge clk);
        check_eq("int3_no_done", 32'(frame_done), 32'd0);
        pulse_int();
        @(negedge clk);
        check_eq("int4_rows_done", 32'(rows_done), 32'd4);
        @(negedge clk);
        check_eq("frame_done_pulse", 32'(frame_done), 32'd1);
        check_eq("busy_fall", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("frame_done_single", 32'(frame_done), 32'd0);
        check_eq("fd_count", 32'(fd_cnt), 32'd1);
        check_eq("idle_after_frame", 32'(dut.state), 32'(IDLE));
        check_eq("frame1_beats", 32'(acc_cnt - acc0), 32'(H * W));

        // Interrupt landing on the last FEED beat keeps its credit.
        step();
        acc0 = acc_cnt;
        start_frame();
        wait_state(WAIT, 100, "f2_prime_wait");
        pulse_int();
        @(negedge clk);
        @(negedge clk);
        hi = (src_ready === 1'b1) ? 1 : 0;
        while (hi < W && hi > 0) begin
            @(negedge clk);
            if (src_ready === 1'b1) hi++;
            else hi = 0;
        end
        check_eq("f2_feed_high", 32'(hi), 32'(W));
        win_interrupt = 1'b1;
        step();
        win_interrupt = 1'b0;
        @(negedge clk);
        check_eq("lastbeat_state", 32'(dut.state), 32'(WAIT));
        check_eq("lastbeat_credit", 32'(dut.credits), 32'd1);
        check_eq("lastbeat_rdy_low", 32'(src_ready), 32'd0);
        check_eq("lastbeat_rows_sent", 32'(rows_sent), 32'd5);
        @(negedge clk);
        check_eq("lastbeat_refeed", 32'(dut.state), 32'(FEED));
        check_eq("lastbeat_rdy_high", 32'(src_ready), 32'd1);
        wait_state(DRAIN, 40, "f2_drain");
        check_eq("f2_rows_sent", 32'(rows_sent), 32'd6);
        @(negedge clk);
        check_eq("f2_beats", 32'(acc_cnt - acc0), 32'(H * W));
        pulse_int();
        pulse_int();
        wait_frame_done(10, "f2_frame_done");
        check_eq("f2_rows_done", 32'(rows_done), 32'd4);

        // Stalling source during PRIME.
        step();
        src_valid = 1'b0;
        acc0 = acc_cnt;
        start_frame();
        for (int i = 0; i < 300 && dut.state != WAIT; i++) begin
            src_valid = pat[i % 4];
            step();
        end
        check_eq("stall_state", 32'(dut.state), 32'(WAIT));
        check_eq("stall_rows_sent", 32'(rows_sent), 32'd4);
        src_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("stall_beats", 32'(acc_cnt - acc0), 32'(4 * W));
        check_eq("stall_sb_empty", 32'(sb_q.size()), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", 32'(busy), 32'd0);

        // Credit overflow while priming.
        acc0 = acc_cnt;
        start_frame();
        repeat (4) pulse_int();
        @(negedge clk);
        check_eq("ovf_state", 32'(dut.state), 32'(PRIME));
        check_eq("ovf_credits", 32'(dut.credits), 32'd3);
        check_eq("ovf_err", 32'(credit_err), 32'd1);
        check_eq("ovf_rows_done", 32'(rows_done), 32'd4);
        wait_frame_done(200, "ovf_frame_done");
        check_eq("ovf_err_sticky", 32'(credit_err), 32'd1);
        check_eq("ovf_credits_drained", 32'(dut.credits), 32'd0);
        check_eq("ovf_beats", 32'(acc_cnt - acc0), 32'(H * W));
        step();
        start_frame();
        @(negedge clk);
        check_eq("err_cleared_by_start", 32'(credit_err), 32'd0);

        // Reset mid-row at rows_sent=3, then re-prime from beat 0.
        begin
            int n = 0;
            while (rows_sent != 12'd3 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check_eq("rst_rows3", 32'(rows_sent), 32'd3);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check_reset_outputs("midrow_rst");
        rst = 1'b0;
        step();
        acc0 = acc_cnt;
        start_frame();
        @(negedge clk);
        count_ready(4 * W, "reprime_ready_cycles");
        check_eq("reprime_rows_sent", 32'(rows_sent), 32'd4);
        @(negedge clk);
        check_eq("reprime_beats", 32'(acc_cnt - acc0), 32'(4 * W));
        check_eq("reprime_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/row_feed_scheduler.md
# row_feed_scheduler

Sequences pixel delivery from an upstream pixel source into the 3x3 window controller, which has four row buffers, a 3-row read threshold and an end-of-row interrupt. It primes the row buffers with four rows, then releases exactly one further row per window-row interrupt, so an unread row is never overwritten. It counts issued and processed rows and signals frame completion.

## Interface
- IMG_WIDTH, 512, pixels per row; must match the window controller.
- IMG_HEIGHT, 512, rows per frame; legal range 4 to 4095.
- PIX_W, 8, pixel width in bits.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame start request; ignored while busy=1.
- src_data  in  PIX_W  upstream pixel.
- src_valid  in  1  upstream pixel valid.
- src_ready  out  1  scheduler accepts src_data this cycle.
- pix_out  out  PIX_W  pixel to the window controller.
- pix_out_valid  out  1  pixel valid to the window controller.
- win_interrupt  in  1  one-cycle pulse from the window controller marking one window row fully read.
- busy  out  1  high from the start acceptance until frame_done.
- frame_done  out  1  one-cycle pulse when the frame is complete.
- rows_sent  out  12  rows fully forwarded in the current frame.
- rows_done  out  12  window rows reported complete in the current frame.
- credit_err  out  1  sticky flag for credit-counter overflow; cleared by rst or an accepted start.

## Operation
- States:
  - IDLE: start=1 clears the counters and goes to PRIME.
  - PRIME: forwards 4*IMG_WIDTH pixels, then goes to WAIT.
  - WAIT: if rows_sent==IMG_HEIGHT, goes to DRAIN. Else if credits>0, decrements credits and goes to FEED.
  - FEED: forwards IMG_WIDTH pixels, then goes back to WAIT.
  - DRAIN: when rows_done==IMG_HEIGHT-2, pulses frame_done and goes to IDLE.
- src_ready is 1 only in PRIME and FEED. A beat transfers when src_valid&src_ready.
- Beat counter (log2 IMG_WIDTH bits) counts transferred beats and wraps at IMG_WIDTH-1.
  - rows_sent increments on the beat that wraps the counter.
  - PRIME exits on the fourth wrap; FEED exits on the first wrap.
- Credits: 2-bit counter.
  - win_interrupt increments it.
  - The WAIT->FEED transition decrements it.
  - A simultaneous increment and decrement leaves the value unchanged.
  - An increment at value 3 holds 3 and sets credit_err.
- rows_done increments on every win_interrupt, in any state.
- A win_interrupt in IDLE is counted in rows_done, adds no credit and does not set credit_err.
- Source stalls (src_valid=0) simply pause the beat counter. There is no timeout.
- The final row may arrive while credits remain. Leftover credits are discarded when the FSM enters DRAIN.

## Timing
- Reset values:
  - src_ready=0, pix_out=0, pix_out_valid=0, busy=0, frame_done=0, rows_sent=0, rows_done=0, credit_err=0.
  - State IDLE, credits=0.
- rst asserted mid-frame aborts on the next edge: all state returns to the reset values and partially fed rows are abandoned. The window controller must be reset in the same cycle.
- start->src_ready: start is sampled at edge N; src_ready=1 from cycle N+1.
- Forward latency is one cycle. pix_out and pix_out_valid are registered copies of the accepted beat. pix_out_valid=0 holds pix_out at its last value.
- src_ready is a registered function of state, so it does not depend combinationally on src_valid.
- The last-beat edge moves the FSM to WAIT, so src_ready is 0 on the following cycle.
- Interrupt->feed: an interrupt at edge N with the FSM in WAIT and credits=0 gives credits=1 at N+1, FEED at N+2 and src_ready=1 at N+2.
- busy rises with the start acceptance (cycle N+1) and falls in the same cycle that frame_done is high.
- Maximum throughput is one pixel per clock within a row.

## Structure
- Shared package img_pkg holds:
  - IMG_WIDTH, IMG_HEIGHT and PIX_W defaults.
  - PRIME_ROWS=4.
  - The state enum IDLE/PRIME/WAIT/FEED/DRAIN.
  - ROW_CNT_W=12.
- No sub-module. Counters and the FSM are flat inside row_feed_scheduler.

## Test plan
- Use IMG_WIDTH=8, IMG_HEIGHT=6, src_valid tied 1, start pulse:
  - src_ready is high for 32 consecutive cycles, then low.
  - rows_sent=4 and the state is WAIT.
- From that WAIT state, issue two win_interrupt pulses 20 cycles apart:
  - Each releases exactly 8 beats.
  - rows_sent reaches 6.
  - After the further interrupts (4 total), rows_done=4 and frame_done pulses once.
  - busy falls in the same cycle.
- Assert a win_interrupt on the last beat of FEED:
  - The credit is retained.
  - The next FEED starts 2 cycles after the WAIT entry.
  - No beat is lost.
- Toggle src_valid 1,0,0,1 during PRIME:
  - pix_out_valid mirrors the accepted beats one cycle later.
  - pix_out data order matches the source order.
  - The beat count is still exactly 32.
- Pulse win_interrupt 4 times while the FSM is in PRIME:
  - credits=3.
  - credit_err=1 and stays set until the next start.
- Assert rst at rows_sent=3 mid-row:
  - The next cycle shows all outputs at their reset values.
  - A new start re-primes from beat 0.
